// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the digit-serial multiplier sequencer.
package mul_seq_pkg;

    // Sequencer states: wait for operands, step through digit pairs, hold product
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand digit width and width of one digit-by-digit partial product
    localparam int DIG_W = 2;
    localparam int PP_W  = 4;

endpackage

// File: rtl/mul_seq_ctrl_mul2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier; the one arithmetic core
// that the sequencer reuses for every digit pair.
module mul_seq_ctrl_mul2x2
    import mul_seq_pkg::*;
(
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    output logic [PP_W-1:0]  p
);

    // Zero-extend both digits so the product keeps all four bits
    assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Digit-serial W x W unsigned multiplier built around a single 2x2 core,
// with valid/ready handshakes on the operand and product sides.
// Optional build macro: MUL_SEQ_ZERO_SKIP_EN -- when defined, an operand pair
// containing a zero goes straight to DONE with a zero product.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    localparam int D     = W / DIG_W;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = 2 * IDX_W;
    localparam int SH_W  = IDX_W + 2;
    localparam int P_W   = 2 * W;
    localparam logic [IDX_W-1:0] LAST_DIG = IDX_W'(D - 1);

    state_t            state;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [P_W-1:0]    acc;
    logic [CNT_W-1:0]  cnt;

    logic [IDX_W-1:0]  dig_i;
    logic [IDX_W-1:0]  dig_j;
    logic [DIG_W-1:0]  a_dig;
    logic [DIG_W-1:0]  b_dig;
    logic [PP_W-1:0]   pp;
    logic [SH_W-1:0]   shamt;
    logic [P_W-1:0]    pp_shift;
    logic              zero_skip;

    // Counter high half walks multiplicand digits, low half walks multiplier digits
    assign dig_i = cnt[CNT_W-1:IDX_W];
    assign dig_j = cnt[IDX_W-1:0];

`ifdef MUL_SEQ_ZERO_SKIP_EN
    assign zero_skip = (in_a == '0) || (in_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Select the current digit pair and align its partial product
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        a_dig    = op_a[DIG_W*dig_i +: DIG_W];
        b_dig    = op_b[DIG_W*dig_j +: DIG_W];
        shamt    = (SH_W'(dig_i) + SH_W'(dig_j)) << 1;
        pp_shift = P_W'(pp) << shamt;
    end

    mul_seq_ctrl_mul2x2 u_mul2x2 (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Sequencer FSM: accept operands, accumulate D*D partial products, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state here is a handful of flops, so every register is reset and a
            // reset mid-operation leaves nothing behind.
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every branch reads
            // the pre-edge values of acc and cnt.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= zero_skip ? DONE : RUN;
                    end
                end
                RUN: begin
                    acc <= acc + pp_shift;
                    if (dig_j == LAST_DIG) begin
                        cnt <= {dig_i + IDX_W'(1), {IDX_W{1'b0}}};
                        if (dig_i == LAST_DIG) begin
                            state <= DONE;
                        end
                    end else begin
                        cnt <= {dig_i, dig_j + IDX_W'(1)};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come from the state register alone
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_p     = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl at W=8: vector table plus hand-written
// sequences for output stall, busy-time input and reset during RUN.
module tb_mul_seq_ctrl;

    localparam int W       = 8;
    localparam int LAT_RUN = 16;
    localparam int LAT_MAX = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        string       name;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    mul_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_SEQ_ZERO_SKIP_EN
        if (a == 8'h00 || b == 8'h00) return 0;
`endif
        return LAT_RUN;
    endfunction

    // Wait (bounded) for out_valid; n counts edges after the acceptance edge
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < LAT_MAX) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One complete transaction with immediate product acceptance
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input string name);
        int n;
        @(negedge clk);
        check({name, ".in_ready_before"}, 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, ".busy"}, 32'(busy), 32'd1);
        check({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        check({name, ".latency"}, 32'(n), 32'(exp_lat(a, b)));
        check({name, ".out_p"}, 32'(out_p), 32'(p));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".in_ready_after"}, 32'(in_ready), 32'd1);
        check({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;

        vecs[0] = '{8'h03, 8'h03, 16'h0009, "3x3"};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, "ffxff"};
        vecs[2] = '{8'hA5, 8'h3C, 16'h26AC, "a5x3c"};
        vecs[3] = '{8'h1B, 8'hE4, 16'h180C, "digit_sweep"};
        vecs[4] = '{8'h12, 8'h34, 16'h03A8, "12x34"};
        vecs[5] = '{8'hA5, 8'h00, 16'h0000, "a5x00"};
        vecs[6] = '{8'h00, 8'h00, 16'h0000, "00x00"};
        vecs[7] = '{8'h80, 8'h02, 16'h0100, "80x02"};
        vecs[8] = '{8'hFF, 8'h01, 16'h00FF, "ffx01"};
        vecs[9] = '{8'hC8, 8'h64, 16'h4E20, "c8x64"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_p", 32'(out_p), 32'h0);
        check("reset.busy", 32'(busy), 32'd0);

        for (int v = 0; v < NVEC; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].name);
        end

        // Output stall with unrelated operands offered while busy
        @(negedge clk);
        in_a     = 8'hA5;
        in_b     = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_a = 8'h11;
        in_b = 8'h22;
        check("stall.in_ready_run", 32'(in_ready), 32'd0);
        wait_valid(n);
        check("stall.latency", 32'(n), 32'(LAT_RUN));
        for (int s = 0; s < 5; s++) begin
            check("stall.out_valid", 32'(out_valid), 32'd1);
            check("stall.out_p", 32'(out_p), 32'h26AC);
            check("stall.in_ready_done", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall.in_ready_after", 32'(in_ready), 32'd1);
        check("stall.busy_after", 32'(busy), 32'd0);

        // Reset asserted on RUN cycle 7
        @(negedge clk);
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rstrun.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstrun.in_ready", 32'(in_ready), 32'd1);
        check("rstrun.out_valid", 32'(out_valid), 32'd0);
        check("rstrun.out_p", 32'(out_p), 32'h0);
        check("rstrun.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstrun.no_output", 32'(out_valid), 32'd0);
        run_op(8'h12, 8'h34, 16'h03A8, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
